// File: rtl/pci_rr_arbiter.sv
// pci_rr_arbiter: PCI central arbiter with round-robin or fixed-priority
// selection, bus parking, a one-cycle dead GNT gap between owners and a
// GRANT-state timeout that revokes a grant the initiator never used.
module pci_rr_arbiter #(
  parameter int N_MASTERS = 8,
  parameter int PARK_ID   = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         RST_N,
  input  logic [N_MASTERS-1:0]         REQ,
  input  logic                         FRAME,
  input  logic                         IRDY,
  input  logic                         PRIO_MODE,
  output logic [N_MASTERS-1:0]         GNT,
  output logic [$clog2(N_MASTERS)-1:0] OWNER_ID,
  output logic                         TIMEOUT_EVT
);

  localparam int                   IW        = $clog2(N_MASTERS);
  localparam logic [7:0]           TO_LIMIT  = 8'(TIMEOUT);
  localparam logic [IW-1:0]        OWNER_RST = IW'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] GNT_PARK  = ~(N_MASTERS'(1) << PARK_ID);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_GRANT,
    ST_BUSY
  } state_t;

  state_t               state;
  logic [IW-1:0]        win;
  logic [7:0]           cnt;
  logic [7:0]           cnt_inc;
  logic [N_MASTERS-1:0] req_act;
  logic [N_MASTERS-1:0] upper_mask;
  logic [N_MASTERS-1:0] req_upper;
  logic [IW-1:0]        rr_win;
  logic [IW-1:0]        fp_win;
  logic [IW-1:0]        pick;
  logic                 any_req;
  logic                 bus_idle;

  // Index of the lowest asserted bit of v (0 when v is empty).
  function automatic logic [IW-1:0] lowest_set(input logic [N_MASTERS-1:0] v);
    lowest_set = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IW'(i);
    end
  endfunction

  // Active-low grant vector with only bit idx low.
  function automatic logic [N_MASTERS-1:0] onehot_low(input logic [IW-1:0] idx);
    onehot_low = ~(N_MASTERS'(1) << idx);
  endfunction

  assign req_act  = ~REQ;
  assign any_req  = |req_act;
  assign bus_idle = FRAME & IRDY;
  assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Requesters strictly above the last owner are searched first; if none,
  // the search wraps to the lowest requester, giving (OWNER_ID+1) mod N order.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      upper_mask[i] = (IW'(i) > OWNER_ID);
    end
  end

  assign req_upper = req_act & upper_mask;
  assign rr_win    = (|req_upper) ? lowest_set(req_upper) : lowest_set(req_act);
  assign fp_win    = lowest_set(req_act);
  assign pick      = PRIO_MODE ? fp_win : rr_win;

  // Arbitration FSM; GNT, OWNER_ID and TIMEOUT_EVT are all registered here.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      GNT         <= '1;
      OWNER_ID    <= OWNER_RST;
      TIMEOUT_EVT <= 1'b0;
      cnt         <= '0;
      win         <= '0;
    end else begin
      TIMEOUT_EVT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!any_req) begin
            GNT <= GNT_PARK;
          end else if (bus_idle) begin
            win <= pick;
            cnt <= '0;
            if (!GNT[pick]) begin
              // Winner already holds the parked grant: no gap needed.
              state <= ST_GRANT;
            end else begin
              GNT   <= '1;
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          GNT   <= onehot_low(win);
          cnt   <= '0;
          state <= ST_GRANT;
        end
        ST_GRANT: begin
          if (!FRAME) begin
            GNT      <= '1;
            OWNER_ID <= win;
            state    <= ST_BUSY;
          end else if (REQ[win]) begin
            GNT   <= '1;
            state <= ST_IDLE;
          end else if (cnt_inc >= TO_LIMIT) begin
            GNT         <= '1;
            TIMEOUT_EVT <= 1'b1;
            OWNER_ID    <= win;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_BUSY: begin
          GNT <= '1;
          if (bus_idle) state <= ST_IDLE;
        end
        default: begin
          GNT   <= '1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// tb_pci_rr_arbiter: directed scenarios plus a randomized run checked against
// a cycle-level behavioural model of the arbiter (8 masters, park on 0,
// timeout 16). A second 4-master instance checks round-robin wrap.
module tb_pci_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       frame;
  logic       irdy;
  logic       prio;
  logic [7:0] gnt;
  logic [2:0] owner;
  logic       evt;
  logic [3:0] req4;
  logic [3:0] gnt4;
  logic [1:0] owner4;
  logic       evt4;

  int n_vec = 0;
  int n_err = 0;

  localparam int PH_IDLE  = 0;
  localparam int PH_GAP   = 1;
  localparam int PH_GRANT = 2;
  localparam int PH_BUSY  = 3;

  // Model: which master currently sees GNT low (-1 = none), last owner,
  // tenure phase, chosen winner and cycles spent granted.
  int m_holder;
  int m_owner;
  int m_phase;
  int m_w;
  int m_age;
  bit m_evt;

  always #5 clk = ~clk;

  pci_rr_arbiter #(.N_MASTERS(8), .PARK_ID(0), .TIMEOUT(16)) dut (
    .clk(clk), .RST_N(rst_n), .REQ(req), .FRAME(frame), .IRDY(irdy),
    .PRIO_MODE(prio), .GNT(gnt), .OWNER_ID(owner), .TIMEOUT_EVT(evt)
  );

  pci_rr_arbiter #(.N_MASTERS(4), .PARK_ID(0), .TIMEOUT(16)) dut4 (
    .clk(clk), .RST_N(rst_n), .REQ(req4), .FRAME(frame), .IRDY(irdy),
    .PRIO_MODE(prio), .GNT(gnt4), .OWNER_ID(owner4), .TIMEOUT_EVT(evt4)
  );

  function automatic int model_pick(input logic [7:0] r, input logic p, input int own);
    int c;
    model_pick = -1;
    if (p) begin
      for (int i = 7; i >= 0; i--) if (!r[i]) model_pick = i;
    end else begin
      for (int k = 8; k >= 1; k--) begin
        c = (own + k) % 8;
        if (!r[c]) model_pick = c;
      end
    end
  endfunction

  function automatic logic [7:0] model_gnt();
    logic [7:0] g;
    g = 8'hFF;
    if (m_holder >= 0) g[m_holder] = 1'b0;
    return g;
  endfunction

  function automatic int first_low(input logic [7:0] g);
    first_low = -1;
    for (int i = 7; i >= 0; i--) if (!g[i]) first_low = i;
  endfunction

  task automatic model_edge();
    bit idle_bus;
    int w;
    idle_bus = frame && irdy;
    if (!rst_n) begin
      m_phase = PH_IDLE; m_holder = -1; m_owner = 7; m_evt = 0; m_age = 0;
    end else begin
      m_evt = 0;
      case (m_phase)
        PH_IDLE: begin
          if (req == 8'hFF) begin
            m_holder = 0;
          end else if (idle_bus) begin
            w = model_pick(req, prio, m_owner);
            m_w = w;
            m_age = 0;
            if (m_holder == w) m_phase = PH_GRANT;
            else begin m_holder = -1; m_phase = PH_GAP; end
          end
        end
        PH_GAP: begin
          m_holder = m_w; m_age = 0; m_phase = PH_GRANT;
        end
        PH_GRANT: begin
          m_age++;
          if (!frame) begin
            m_owner = m_w; m_holder = -1; m_phase = PH_BUSY;
          end else if (req[m_w]) begin
            m_holder = -1; m_phase = PH_IDLE;
          end else if (m_age >= 16) begin
            m_owner = m_w; m_holder = -1; m_evt = 1; m_phase = PH_IDLE;
          end
        end
        default: begin
          m_holder = -1;
          if (idle_bus) m_phase = PH_IDLE;
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    frame = 1'b1;
    irdy  = 1'b1;
  endtask

  // Steps until the selected DUT shows a grant; counts all-ones cycles seen.
  task automatic wait_grant(input bit use4, output int idx, output int ones, output bit ok);
    ok = 1'b0; idx = -1; ones = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      idx = first_low(use4 ? {4'hF, gnt4} : gnt);
      if (idx >= 0) begin
        ok = 1'b1;
        break;
      end
      ones++;
    end
  endtask

  task automatic finish_txn();
    frame = 1'b1; irdy = 1'b0;
    step();
    irdy = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req = 8'hFF; req4 = 4'hF; frame = 1'b1; irdy = 1'b1; prio = 1'b0; rst_n = 1'b0;
    step();
    step();
    n_vec++; if (gnt !== 8'hFF) begin n_err++; $display("FAIL reset_gnt: got %h expected %h", gnt, 8'hFF); end
    n_vec++; if (owner !== 3'd7) begin n_err++; $display("FAIL reset_owner: got %0d expected 7", owner); end
    n_vec++; if (evt !== 1'b0) begin n_err++; $display("FAIL reset_evt: got %b expected 0", evt); end
    n_vec++; if (owner4 !== 2'd3) begin n_err++; $display("FAIL reset_owner4: got %0d expected 3", owner4); end
  endtask

  task automatic test_park();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_vec++; if (gnt !== 8'hFE) begin n_err++; $display("FAIL park_gnt[%0d]: got %h expected %h", k, gnt, 8'hFE); end
    end
  endtask

  task automatic test_handover();
    req = 8'hFD;
    step();
    n_vec++; if (gnt !== 8'hFF) begin n_err++; $display("FAIL handover_gap: got %h expected %h", gnt, 8'hFF); end
    step();
    n_vec++; if (gnt !== 8'hFD) begin n_err++; $display("FAIL handover_grant: got %h expected %h", gnt, 8'hFD); end
    frame = 1'b0;
    step();
    n_vec++; if (gnt !== 8'hFF) begin n_err++; $display("FAIL handover_busy_gnt: got %h expected %h", gnt, 8'hFF); end
    n_vec++; if (owner !== 3'd1) begin n_err++; $display("FAIL handover_owner: got %0d expected 1", owner); end
    req = 8'hFF;
    finish_txn();
    step();
    n_vec++; if (gnt !== 8'hFE) begin n_err++; $display("FAIL handover_repark: got %h expected %h", gnt, 8'hFE); end
    // Parked master 0 requests: granted without a gap cycle.
    req = 8'hFE;
    step();
    n_vec++; if (gnt !== 8'hFE) begin n_err++; $display("FAIL park_hit_grant: got %h expected %h", gnt, 8'hFE); end
    frame = 1'b0;
    step();
    n_vec++; if (owner !== 3'd0) begin n_err++; $display("FAIL park_hit_owner: got %0d expected 0", owner); end
    req = 8'hFF;
    finish_txn();
  endtask

  task automatic test_order(input bit fixed);
    int idx, ones, exp_id;
    bit ok;
    req4 = 4'hF; prio = fixed; req = 8'hF0;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      exp_id = fixed ? 0 : k % 4;
      wait_grant(1'b0, idx, ones, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL order_wait[%0d]: got no grant expected master %0d", k, exp_id); end
      n_vec++; if (idx != exp_id) begin n_err++; $display("FAIL order_id[%0d] prio=%0b: got %0d expected %0d", k, fixed, idx, exp_id); end
      n_vec++; if (ones < 1) begin n_err++; $display("FAIL order_gap[%0d]: got %0d idle cycles expected >=1", k, ones); end
      frame = 1'b0;
      step();
      n_vec++; if (owner !== 3'(exp_id)) begin n_err++; $display("FAIL order_owner[%0d]: got %0d expected %0d", k, owner, exp_id); end
      n_vec++; if (gnt !== 8'hFF) begin n_err++; $display("FAIL order_busy_gnt[%0d]: got %h expected %h", k, gnt, 8'hFF); end
      finish_txn();
    end
    req = 8'hFF; prio = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int idx, ones, glen;
    bit ok;
    req = 8'hDF;
    apply_reset();
    wait_grant(1'b0, idx, ones, ok);
    n_vec++; if (idx != 5) begin n_err++; $display("FAIL timeout_first: got %0d expected 5", idx); end
    req = 8'h9B;
    glen = 1;
    for (int t = 0; t < 40; t++) begin
      step();
      n_vec++; if (evt !== 1'b0 && gnt === 8'hDF) begin n_err++; $display("FAIL timeout_early_evt: got %b expected 0", evt); end
      if (gnt === 8'hDF) glen++;
      else break;
    end
    n_vec++; if (glen != 16) begin n_err++; $display("FAIL timeout_len: got %0d expected 16", glen); end
    n_vec++; if (gnt !== 8'hFF) begin n_err++; $display("FAIL timeout_gnt: got %h expected %h", gnt, 8'hFF); end
    n_vec++; if (evt !== 1'b1) begin n_err++; $display("FAIL timeout_evt: got %b expected 1", evt); end
    n_vec++; if (owner !== 3'd5) begin n_err++; $display("FAIL timeout_owner: got %0d expected 5", owner); end
    step();
    n_vec++; if (evt !== 1'b0) begin n_err++; $display("FAIL timeout_pulse: got %b expected 0", evt); end
    wait_grant(1'b0, idx, ones, ok);
    n_vec++; if (idx != 6) begin n_err++; $display("FAIL timeout_next: got %0d expected 6", idx); end
    req = 8'hFF;
    step();
  endtask

  task automatic test_withdraw();
    int idx, ones;
    bit ok;
    req = 8'hFB;
    apply_reset();
    wait_grant(1'b0, idx, ones, ok);
    n_vec++; if (idx != 2) begin n_err++; $display("FAIL withdraw_grant: got %0d expected 2", idx); end
    req = 8'hFF;
    step();
    n_vec++; if (gnt !== 8'hFF) begin n_err++; $display("FAIL withdraw_gnt: got %h expected %h", gnt, 8'hFF); end
    n_vec++; if (owner !== 3'd7) begin n_err++; $display("FAIL withdraw_owner: got %0d expected 7", owner); end
    step();
    n_vec++; if (gnt !== 8'hFE) begin n_err++; $display("FAIL withdraw_park: got %h expected %h", gnt, 8'hFE); end
  endtask

  task automatic test_reset_busy();
    int idx, ones;
    bit ok;
    req = 8'hFD;
    apply_reset();
    wait_grant(1'b0, idx, ones, ok);
    frame = 1'b0;
    step();
    n_vec++; if (owner !== 3'd1) begin n_err++; $display("FAIL rstbusy_owner_pre: got %0d expected 1", owner); end
    rst_n = 1'b0;
    step();
    n_vec++; if (gnt !== 8'hFF) begin n_err++; $display("FAIL rstbusy_gnt: got %h expected %h", gnt, 8'hFF); end
    n_vec++; if (owner !== 3'd7) begin n_err++; $display("FAIL rstbusy_owner: got %0d expected 7", owner); end
    rst_n = 1'b1; req = 8'hFF;
    step();
    n_vec++; if (gnt !== 8'hFE) begin n_err++; $display("FAIL rstbusy_park: got %h expected %h", gnt, 8'hFE); end
    frame = 1'b1;
    step();
  endtask

  task automatic test_wrap4();
    int idx, ones, exp_id;
    bit ok;
    req = 8'hFF; req4 = 4'h0; prio = 1'b0;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      wait_grant(1'b1, idx, ones, ok);
      n_vec++; if (idx != exp_id) begin n_err++; $display("FAIL wrap4_id[%0d]: got %0d expected %0d", k, idx, exp_id); end
      n_vec++; if (ones < 1) begin n_err++; $display("FAIL wrap4_gap[%0d]: got %0d expected >=1", k, ones); end
      frame = 1'b0;
      step();
      n_vec++; if (owner4 !== 2'(exp_id)) begin n_err++; $display("FAIL wrap4_owner[%0d]: got %0d expected %0d", k, owner4, exp_id); end
      finish_txn();
    end
    req4 = 4'hF;
    step();
  endtask

  task automatic test_random();
    req = 8'hFF; prio = 1'b0;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) req = 8'($urandom);
      if ($urandom_range(0, 49) == 0) prio = ~prio;
      frame = ($urandom_range(0, 29) != 0);
      irdy  = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
      n_vec++; if (gnt !== model_gnt()) begin n_err++; $display("FAIL rand_gnt[%0d]: got %h expected %h", c, gnt, model_gnt()); end
      n_vec++; if (owner !== 3'(m_owner)) begin n_err++; $display("FAIL rand_owner[%0d]: got %0d expected %0d", c, owner, m_owner); end
      n_vec++; if (evt !== m_evt) begin n_err++; $display("FAIL rand_evt[%0d]: got %b expected %b", c, evt, m_evt); end
      n_vec++; if ($countones(~gnt) > 1) begin n_err++; $display("FAIL rand_onehot[%0d]: got %h expected at most one low bit", c, gnt); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    m_holder = -1; m_owner = 7; m_phase = PH_IDLE; m_w = 0; m_age = 0; m_evt = 0;
    test_reset();
    test_park();
    test_handover();
    test_order(1'b0);
    test_order(1'b1);
    test_timeout();
    test_withdraw();
    test_reset_busy();
    test_wrap4();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
